// File: rtl/mulchan_rr_rd_arbiter_if.sv
// Handshake bundle between the per-channel read controllers, the round-robin read arbiter
// and the AXI read master.
interface mulchan_rr_rd_arbiter_if #(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 30
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM-1:0]        rd_req;
  logic [CH_NUM*ADDR_W-1:0] rd_addr;
  logic                     rd_done;
  logic [CH_NUM-1:0]        rd_grant;
  logic [CH_W-1:0]          grant_ch;
  logic                     axi_rd_start;
  logic [ADDR_W-1:0]        axi_rd_addr;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    input  rd_req, rd_addr, rd_done,
    output rd_grant, grant_ch, axi_rd_start, axi_rd_addr, busy, timeout_err
  );

  modport slave (
    output rd_req, rd_addr, rd_done,
    input  rd_grant, grant_ch, axi_rd_start, axi_rd_addr, busy, timeout_err
  );
endinterface

// File: rtl/mulchan_rr_rd_arbiter.sv
// N-channel round-robin read arbiter: one grant at a time, one start pulse per grant,
// released by rd_done or by the watchdog.
module mulchan_rr_rd_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int ADDR_W      = 30,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                     clk,
  input logic                     rst_n,
  mulchan_rr_rd_arbiter_if.master bus
);
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TmoEn = (TIMEOUT_CYC > 0);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [CH_NUM-1:0]   rd_grant_q;
  logic [CH_W-1:0]     grant_ch_q;
  logic                axi_rd_start_q;
  logic [ADDR_W-1:0]   axi_rd_addr_q;
  logic                busy_q;
  logic                timeout_err_q;
  logic [TMO_W-1:0]    tmo_cnt_q;

  logic [CH_NUM-1:0]   hi_mask;
  logic [CH_NUM-1:0]   req_hi;
  logic [CH_NUM-1:0]   pick;
  logic [CH_NUM-1:0]   win_oh;
  logic [CH_W-1:0]     win_ch;
  logic [ADDR_W-1:0]   win_addr;
  logic                tmo_hit;
  logic                ch_bad;

  // grant_ch_q doubles as the last-served pointer: it only changes at a grant and is
  // never cleared on release, so it always holds the channel last served.
  always_comb begin
    hi_mask  = '0;
    win_oh   = '0;
    win_ch   = '0;
    win_addr = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      hi_mask[i] = (i > int'(grant_ch_q));
    end
    req_hi = bus.rd_req & hi_mask;
    pick   = (|req_hi) ? req_hi : bus.rd_req;
    // Descending scan so the lowest set bit of pick is the one left standing.
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pick[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_ch    = CH_W'(i);
        win_addr  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign tmo_hit = TmoEn && (tmo_cnt_q == TmoLast);
  assign ch_bad  = (int'(grant_ch_q) >= CH_NUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rd_grant_q     <= '0;
      grant_ch_q     <= CH_W'(CH_NUM - 1);
      axi_rd_start_q <= 1'b0;
      axi_rd_addr_q  <= '0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      axi_rd_start_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|bus.rd_req) begin
            state_q        <= StBusy;
            rd_grant_q     <= win_oh;
            grant_ch_q     <= win_ch;
            axi_rd_addr_q  <= win_addr;
            axi_rd_start_q <= 1'b1;
            busy_q         <= 1'b1;
            tmo_cnt_q      <= '0;
          end
        end
        StBusy: begin
          if (ch_bad || bus.rd_done || tmo_hit) begin
            state_q       <= StIdle;
            rd_grant_q    <= '0;
            busy_q        <= 1'b0;
            // rd_done takes precedence over a coincident watchdog expiry.
            timeout_err_q <= tmo_hit && !bus.rd_done && !ch_bad;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          rd_grant_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_grant     = rd_grant_q;
  assign bus.grant_ch     = grant_ch_q;
  assign bus.axi_rd_start = axi_rd_start_q;
  assign bus.axi_rd_addr  = axi_rd_addr_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_mulchan_rr_rd_arbiter.sv
// Directed bench for the round-robin read arbiter: a 4-channel instance with a short
// watchdog and an 8-channel instance for full rotation.
module tb_mulchan_rr_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mulchan_rr_rd_arbiter_if #(.CH_NUM(4), .ADDR_W(30)) bus4 ();
  mulchan_rr_rd_arbiter_if #(.CH_NUM(8), .ADDR_W(28)) bus8 ();

  mulchan_rr_rd_arbiter #(.CH_NUM(4), .ADDR_W(30), .TIMEOUT_CYC(16)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mulchan_rr_rd_arbiter #(.CH_NUM(8), .ADDR_W(28), .TIMEOUT_CYC(4096)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int checks   = 0;
  int failures = 0;

  logic [29:0] a4[4];
  logic [27:0] a8[8];

  always_comb begin
    bus4.rd_addr = '0;
    for (int i = 0; i < 4; i++) bus4.rd_addr[i*30 +: 30] = a4[i];
  end

  always_comb begin
    bus8.rd_addr = '0;
    for (int i = 0; i < 8; i++) bus8.rd_addr[i*28 +: 28] = a8[i];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert ($onehot0(bus4.rd_grant)) else $error("rd_grant of 4-channel instance multi-hot");
      assert ($onehot0(bus8.rd_grant)) else $error("rd_grant of 8-channel instance multi-hot");
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant4(input int ch);
    check_eq("start4", 64'(bus4.axi_rd_start), 64'd1);
    check_eq("grant4", 64'(bus4.rd_grant), 64'(4'd1 << ch));
    check_eq("gch4",   64'(bus4.grant_ch), 64'(ch));
    check_eq("addr4",  64'(bus4.axi_rd_addr), 64'(a4[ch]));
    check_eq("busy4",  64'(bus4.busy), 64'd1);
  endtask

  // n busy cycles with no further start, grant held on ch, no timeout.
  task automatic hold4(input int ch, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus4.axi_rd_start !== 1'b0 || bus4.rd_grant !== (4'd1 << ch) ||
          bus4.busy !== 1'b1 || bus4.timeout_err !== 1'b0) bad++;
    end
    check_eq("hold4", 64'(bad), 64'd0);
  endtask

  task automatic done4(input int ch);
    bus4.rd_done = 1'b1;
    tick();
    bus4.rd_done = 1'b0;
    check_eq("rel_busy4",  64'(bus4.busy), 64'd0);
    check_eq("rel_grant4", 64'(bus4.rd_grant), 64'd0);
    check_eq("rel_terr4",  64'(bus4.timeout_err), 64'd0);
    check_eq("rel_gch4",   64'(bus4.grant_ch), 64'(ch));
  endtask

  initial begin
    int seq4[5];
    seq4 = '{0, 1, 3, 0, 1};
    a4[0] = 30'h000_1000;
    a4[1] = 30'h000_2001;
    a4[2] = 30'h0AB_CDEF;
    a4[3] = 30'h3FF_FFF0;
    for (int i = 0; i < 8; i++) a8[i] = 28'h111_1111 * 28'(i) + 28'h5;
    bus4.rd_req  = '0;
    bus4.rd_done = 1'b0;
    bus8.rd_req  = '0;
    bus8.rd_done = 1'b0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_grant",  64'(bus4.rd_grant), 64'd0);
    check_eq("rst_gch",    64'(bus4.grant_ch), 64'd3);
    check_eq("rst_start",  64'(bus4.axi_rd_start), 64'd0);
    check_eq("rst_addr",   64'(bus4.axi_rd_addr), 64'd0);
    check_eq("rst_busy",   64'(bus4.busy), 64'd0);
    check_eq("rst_terr",   64'(bus4.timeout_err), 64'd0);
    check_eq("rst_gch8",   64'(bus8.grant_ch), 64'd7);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", 64'(bus4.busy), 64'd0);

    // Rotation over 1011 with rd_done 5 cycles after each start.
    bus4.rd_req = 4'b1011;
    for (int g = 0; g < 5; g++) begin
      tick();
      expect_grant4(seq4[g]);
      hold4(seq4[g], 5);
      if (g == 4) bus4.rd_req = '0;
      done4(seq4[g]);
    end
    tick();
    check_eq("idle_start", 64'(bus4.axi_rd_start), 64'd0);
    check_eq("idle_busy2", 64'(bus4.busy), 64'd0);

    // Single requester; address held while the source changes.
    a4[2] = 30'h123_4567;
    bus4.rd_req = 4'b0100;
    tick();
    expect_grant4(2);
    bus4.rd_req = '0;
    a4[2] = 30'h2AA_AAAA;
    hold4(2, 3);
    check_eq("addr_stable", 64'(bus4.axi_rd_addr), 64'h123_4567);
    done4(2);
    bus4.rd_req = 4'b0100;
    tick();
    expect_grant4(2);
    bus4.rd_req = '0;
    hold4(2, 2);
    done4(2);

    // Request changes during a grant are ignored.
    bus4.rd_req = 4'b0010;
    tick();
    expect_grant4(1);
    bus4.rd_req = 4'b0100;
    hold4(1, 3);
    done4(1);
    check_eq("gap_start", 64'(bus4.axi_rd_start), 64'd0);
    tick();
    expect_grant4(2);
    bus4.rd_req = '0;
    hold4(2, 1);
    done4(2);

    // Watchdog expiry, then skip past the timed-out channel.
    bus4.rd_req = 4'b0011;
    tick();
    expect_grant4(0);
    hold4(0, 15);
    tick();
    check_eq("tmo_busy",  64'(bus4.busy), 64'd0);
    check_eq("tmo_terr",  64'(bus4.timeout_err), 64'd1);
    check_eq("tmo_grant", 64'(bus4.rd_grant), 64'd0);
    check_eq("tmo_gch",   64'(bus4.grant_ch), 64'd0);
    tick();
    check_eq("tmo_pulse", 64'(bus4.timeout_err), 64'd0);
    expect_grant4(1);
    hold4(1, 15);
    bus4.rd_req = '0;
    done4(1);
    tick();
    check_eq("tmo_none", 64'(bus4.timeout_err), 64'd0);
    check_eq("tmo_idle", 64'(bus4.busy), 64'd0);

    // Asynchronous reset during the start cycle.
    bus4.rd_req = 4'b1000;
    tick();
    expect_grant4(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_grant", 64'(bus4.rd_grant), 64'd0);
    check_eq("arst_busy",  64'(bus4.busy), 64'd0);
    check_eq("arst_start", 64'(bus4.axi_rd_start), 64'd0);
    check_eq("arst_addr",  64'(bus4.axi_rd_addr), 64'd0);
    check_eq("arst_gch",   64'(bus4.grant_ch), 64'd3);
    bus4.rd_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus4.rd_done = 1'b1;
    tick();
    bus4.rd_done = 1'b0;
    check_eq("stray_busy",  64'(bus4.busy), 64'd0);
    check_eq("stray_grant", 64'(bus4.rd_grant), 64'd0);
    bus4.rd_req = 4'b1010;
    tick();
    expect_grant4(1);
    bus4.rd_req = '0;
    hold4(1, 1);
    done4(1);

    // 8 channels all requesting: two full rotations.
    bus8.rd_req = 8'hFF;
    for (int g = 0; g < 16; g++) begin
      tick();
      check_eq("start8", 64'(bus8.axi_rd_start), 64'd1);
      check_eq("grant8", 64'(bus8.rd_grant), 64'(8'd1 << (g % 8)));
      check_eq("gch8",   64'(bus8.grant_ch), 64'(g % 8));
      check_eq("addr8",  64'(bus8.axi_rd_addr), 64'(a8[g % 8]));
      tick();
      check_eq("hold8", 64'(bus8.axi_rd_start), 64'd0);
      tick();
      if (g == 15) bus8.rd_req = '0;
      bus8.rd_done = 1'b1;
      tick();
      bus8.rd_done = 1'b0;
      check_eq("rel8", 64'(bus8.busy), 64'd0);
    end
    tick();
    check_eq("idle8", 64'(bus8.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mulchan_rr_rd_arbiter.md
Name: mulchan_rr_rd_arbiter

Overview:
Parametrised N-channel read arbiter for the DDR3 read path. It sits between the per-channel read controllers and the single AXI read master. It grants one channel at a time with rotating round-robin priority and issues one start pulse plus a registered address to the AXI master. The grant is held until the master signals burst completion. A watchdog timeout releases the grant if completion never arrives.

Parameters:
CH_NUM, 4, number of read channels (2..16)
ADDR_W, 30, read address width per channel
TIMEOUT_CYC, 4096, max cycles a grant may be held without rd_done; 0 disables the watchdog
CH_W, derived: max(1, clog2(CH_NUM)), width of the channel index

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
rd_req  in  CH_NUM  level read request; bit i = channel i
rd_addr  in  CH_NUM*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
rd_done  in  1  one-cycle pulse from the AXI read master when a burst completes
rd_grant  out  CH_NUM  registered one-hot grant; all-zero when idle
grant_ch  out  CH_W  index of the granted/last-granted channel
axi_rd_start  out  1  registered one-cycle start pulse to the AXI read master
axi_rd_addr  out  ADDR_W  registered address of the granted channel, stable for the whole grant
busy  out  1  high while a grant is held
timeout_err  out  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset values: rd_grant=0, grant_ch=CH_NUM-1, axi_rd_start=0, axi_rd_addr=0, busy=0, timeout_err=0. FSM resets to IDLE. The internal last pointer resets to CH_NUM-1, so channel 0 has top priority after reset.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If rd_req is nonzero, select the winner by searching from last+1, wrapping modulo CH_NUM, and taking the first set bit.
  - On that clock edge: go to BUSY; rd_grant=onehot(winner); grant_ch=winner; axi_rd_addr=rd_addr[winner]; axi_rd_start=1 for exactly one cycle; busy=1.
  - Latency is 1 cycle from a sampled request to start.
  - If rd_req is zero, stay in IDLE with all outputs idle.
  - rd_done in IDLE is ignored.
- BUSY:
  - The grant and address are held regardless of changes on rd_req (a request dropping or new requests arriving do not matter).
  - axi_rd_start stays 0 after its single pulse; exactly one start is issued per grant.
  - On rd_done: next edge returns to IDLE, rd_grant=0, busy=0, last=grant_ch. grant_ch keeps its value.
  - The earliest next start is 2 cycles after the rd_done cycle, because IDLE always lasts at least one cycle.
- Watchdog (TIMEOUT_CYC>0):
  - The counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC-1 with no rd_done, the next edge performs the same release as rd_done, and timeout_err pulses for 1 cycle.
  - If rd_done and timeout occur in the same cycle, rd_done wins and timeout_err stays 0.
  - The counter width is sized to hold TIMEOUT_CYC-1 without wrap.
- Fairness: a channel just served has the lowest priority at the next arbitration. With all channels requesting continuously, grants follow 0,1,...,CH_NUM-1,0,...
- With a single requester, the same channel is re-granted every arbitration.
- Asynchronous reset mid-grant immediately drops rd_grant, busy and axi_rd_start, and restores all reset values. A later rd_done pulse is ignored because the FSM is in IDLE.
- rd_grant is always one-hot or zero, never multi-hot.
- Out-of-range channel indices are unreachable. If grant_ch ever decodes to one, the FSM returns to IDLE.

Test Plan:
- Reset, then rd_req=4'b1011 held, rd_done 5 cycles after each start -> grants in order ch0, ch1, ch3, ch0, ch1; exactly one axi_rd_start per grant; axi_rd_addr equals that channel's address.
- rd_req=4'b0100 alone with rd_addr2=30'h123_4567 -> axi_rd_start and rd_grant=4'b0100 appear 1 cycle after the request is sampled; axi_rd_addr=30'h123_4567 and stays stable while rd_addr2 changes during BUSY.
- During a ch1 grant, rd_req[1] drops and rd_req[2] rises -> grant stays on ch1 until rd_done; ch2 starts 2 cycles after rd_done.
- TIMEOUT_CYC=16, rd_done withheld -> release 16 cycles after start, timeout_err=1 for 1 cycle, next arbitration skips past the timed-out channel. Repeat with rd_done on cycle 15 -> no timeout_err.
- Assert rst_n low mid-BUSY -> all outputs return to 0 asynchronously, grant_ch=CH_NUM-1. A stray rd_done after reset has no effect. The first post-reset grant goes to the lowest requesting channel.
- CH_NUM=8, ADDR_W=28, all requests high -> grants cycle 0..7 twice; rd_grant is never multi-hot (assertion).
